// File: rtl/out_buffer_if.sv
// Handshake and status bundle for out_buffer: 64-bit pair input side, 32-bit word output side.
interface out_buffer_if #(
  parameter int DEPTH = 16
);
  logic [63:0]             data_in;
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             data_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    empty;
  logic [15:0]             ovf_count;

  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid, count, full, empty, ovf_count
  );

  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, data_out, out_valid, count, full, empty, ovf_count
  );
endinterface

// File: rtl/out_buffer.sv
// FIFO of 64-bit word pairs serialized onto a 32-bit stream, high word first.
// Optional dropped-write counter enabled by defining OUT_BUFFER_OVF_CNT_EN.
module out_buffer #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  out_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   hold_q, hold_d;
  state_t        state_q, state_d;

  logic full, empty, push, pop;
  logic [31:0] data_out;
  logic        out_valid;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // A pop in the same cycle never frees room for a write while full.
  assign push  = bus.in_valid && !full;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    out_valid = 1'b0;
    data_out  = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SEND_HI;
        end
      end
      SEND_HI: begin
        out_valid = 1'b1;
        data_out  = hold_q[63:32];
        if (bus.out_ready) state_d = SEND_LO;
      end
      SEND_LO: begin
        out_valid = 1'b1;
        data_out  = hold_q[31:0];
        if (bus.out_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = SEND_HI;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    hold_d   = pop ? mem_q[rd_ptr_q] : hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      state_q  <= state_d;
    end
  end

  // Storage array is not reset; reset only invalidates it through the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_in;
  end

`ifdef OUT_BUFFER_OVF_CNT_EN
  logic [15:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (bus.in_valid && full && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end

  assign bus.ovf_count = ovf_q;
`else
  assign bus.ovf_count = 16'h0000;
`endif

  assign bus.in_ready  = !full;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.data_out  = data_out;
  assign bus.out_valid = out_valid;
endmodule
